// File: rtl/hub75_rx.sv
// hub75_rx: HUB75 panel-input receiver. Synchronizes the panel bus into the
// system clock domain, rebuilds each latched row pair from the shift stream
// and drains it as a valid/ready pixel stream (upper row, then lower row).
// Optional build macro: HUB75_RX_ERROR_CHECK_EN enables LENGTH_ERR/OVERRUN.
module hub75_rx #(
    parameter  int unsigned COLS     = 32,
    parameter  int unsigned ROWS     = 16,
    localparam int unsigned ROW_BITS = $clog2(ROWS),
    localparam int unsigned COL_BITS = $clog2(COLS)
) (
    input  logic                CLOCK,
    input  logic                RESET_N,
    input  logic                LP_CLOCK,
    input  logic                LP_LATCH,
    input  logic                LP_BLANK,
    input  logic [2:0]          LP_RGB_0,
    input  logic [2:0]          LP_RGB_1,
    input  logic [4:0]          LP_ADDRESS,
    output logic                PIX_VALID,
    input  logic                PIX_READY,
    output logic [ROW_BITS-1:0] PIX_ROW,
    output logic [COL_BITS-1:0] PIX_COL,
    output logic [2:0]          PIX_RGB,
    output logic                LINE_DONE,
    output logic                LENGTH_ERR,
    output logic                OVERRUN
);

    localparam int unsigned HALF_ROWS    = ROWS / 2;
    localparam int unsigned ADDRESS_BITS = (HALF_ROWS > 1) ? $clog2(HALF_ROWS) : 1;
    localparam int unsigned SR_W         = COLS * 3;
    localparam int unsigned IDX_BITS     = $clog2(SR_W);
    localparam int unsigned CNT_BITS     = $clog2(COLS + 2);
    localparam int unsigned SYNC_W       = 9 + ADDRESS_BITS;
    // Bus order {clock, latch, blank, rgb0, rgb1, addr}; blank idles high.
    localparam logic [SYNC_W-1:0] SYNC_RST = {3'b001, {(6 + ADDRESS_BITS){1'b0}}};

    typedef enum logic {S_IDLE, S_DRAIN} state_t;

    logic [SYNC_W-1:0]       r_sync1, r_sync2;
    logic                    r_prev_clk, r_prev_latch, r_prev_blank;
    logic [SR_W-1:0]         r_sr0, r_sr1, r_pend0, r_pend1, r_drain0, r_drain1;
    logic [CNT_BITS-1:0]     r_cnt;
    logic                    r_pending;
    state_t                  r_state;
    logic [ADDRESS_BITS-1:0] r_row_a;
    logic                    r_half;
    logic                    r_valid;
    logic [ROW_BITS-1:0]     r_row;
    logic [COL_BITS-1:0]     r_col;
    logic [2:0]              r_rgb;
    logic                    r_line_done;

    logic                    w_s_clk, w_s_latch, w_s_blank;
    logic [2:0]              w_s_rgb0, w_s_rgb1;
    logic [ADDRESS_BITS-1:0] w_s_addr;
    logic                    w_shift, w_latch, w_unblank;
    logic [SR_W-1:0]         w_sr0_next, w_sr1_next;
    logic [CNT_BITS-1:0]     w_cnt_next;
    logic                    w_start, w_drop, w_accept;
    logic [COL_BITS-1:0]     w_col_inc;
    logic [IDX_BITS-1:0]     w_base;

    // Upper address bits are not part of the row index.
    if (ADDRESS_BITS < 5) begin : g_addr_unused
        logic w_addr_unused;
        assign w_addr_unused = ^LP_ADDRESS[4:ADDRESS_BITS];
    end

    // Two-flop synchronizer shared by strobes and data so both see equal delay.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sync1 <= SYNC_RST;
            r_sync2 <= SYNC_RST;
        end else begin
            r_sync1 <= {LP_CLOCK, LP_LATCH, LP_BLANK, LP_RGB_0, LP_RGB_1,
                        LP_ADDRESS[ADDRESS_BITS-1:0]};
            r_sync2 <= r_sync1;
        end
    end

    assign w_s_clk   = r_sync2[SYNC_W-1];
    assign w_s_latch = r_sync2[SYNC_W-2];
    assign w_s_blank = r_sync2[SYNC_W-3];
    assign w_s_rgb0  = r_sync2[ADDRESS_BITS+3 +: 3];
    assign w_s_rgb1  = r_sync2[ADDRESS_BITS +: 3];
    assign w_s_addr  = r_sync2[ADDRESS_BITS-1:0];

    // Previous synchronized strobe levels for edge detection.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_prev_clk   <= 1'b0;
            r_prev_latch <= 1'b0;
            r_prev_blank <= 1'b1;
        end else begin
            r_prev_clk   <= w_s_clk;
            r_prev_latch <= w_s_latch;
            r_prev_blank <= w_s_blank;
        end
    end

    assign w_shift   = w_s_clk & ~r_prev_clk;
    assign w_latch   = w_s_latch & ~r_prev_latch;
    assign w_unblank = ~w_s_blank & r_prev_blank;

    // Newest bit enters column 0, so the first bit of a row ends at COLS-1.
    assign w_sr0_next = w_shift ? {r_sr0[SR_W-4:0], w_s_rgb0} : r_sr0;
    assign w_sr1_next = w_shift ? {r_sr1[SR_W-4:0], w_s_rgb1} : r_sr1;
    assign w_cnt_next = (w_shift && (r_cnt != CNT_BITS'(COLS + 1)))
                        ? r_cnt + CNT_BITS'(1) : r_cnt;

    assign w_start = w_unblank & r_pending & (r_state == S_IDLE);
    assign w_drop  = w_unblank & r_pending & (r_state == S_DRAIN);

`ifdef HUB75_RX_ERROR_CHECK_EN
    logic w_len_ok;
    logic r_length_err, r_overrun;

    // Count includes a shift landing in the same cycle as the latch.
    assign w_len_ok = (w_cnt_next == CNT_BITS'(COLS));
    assign w_accept = w_latch & w_len_ok;

    // Sticky error flags, cleared only by reset.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_length_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            if (w_latch && !w_len_ok) r_length_err <= 1'b1;
            if (w_drop)               r_overrun    <= 1'b1;
        end
    end

    assign LENGTH_ERR = r_length_err;
    assign OVERRUN    = r_overrun;
`else
    assign w_accept   = w_latch;
    assign LENGTH_ERR = 1'b0;
    assign OVERRUN    = 1'b0;
`endif

    // Shift capture, shift count and pending row buffer.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sr0     <= '0;
            r_sr1     <= '0;
            r_pend0   <= '0;
            r_pend1   <= '0;
            r_cnt     <= '0;
            r_pending <= 1'b0;
        end else begin
            r_sr0 <= w_sr0_next;
            r_sr1 <= w_sr1_next;
            r_cnt <= w_latch ? '0 : w_cnt_next;
            if (w_start || w_drop) r_pending <= 1'b0;
            if (w_accept) begin
                r_pending <= 1'b1;
                r_pend0   <= w_sr0_next;
                r_pend1   <= w_sr1_next;
            end
        end
    end

    assign w_col_inc = r_col + COL_BITS'(1);
    assign w_base    = IDX_BITS'(w_col_inc) * IDX_BITS'(3);

    // Drain FSM: presents 2*COLS beats with valid/ready, then pulses LINE_DONE.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= S_IDLE;
            r_row_a     <= '0;
            r_drain0    <= '0;
            r_drain1    <= '0;
            r_half      <= 1'b0;
            r_valid     <= 1'b0;
            r_row       <= '0;
            r_col       <= '0;
            r_rgb       <= '0;
            r_line_done <= 1'b0;
        end else begin
            r_line_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_state  <= S_DRAIN;
                        r_row_a  <= w_s_addr;
                        r_drain0 <= r_pend0;
                        r_drain1 <= r_pend1;
                    end
                end
                S_DRAIN: begin
                    if (!r_valid) begin
                        r_valid <= 1'b1;
                        r_half  <= 1'b0;
                        r_col   <= '0;
                        r_row   <= ROW_BITS'(r_row_a);
                        r_rgb   <= r_drain0[2:0];
                    end else if (PIX_READY) begin
                        if (r_col == COL_BITS'(COLS - 1)) begin
                            if (r_half) begin
                                r_valid     <= 1'b0;
                                r_line_done <= 1'b1;
                                r_state     <= S_IDLE;
                            end else begin
                                r_half <= 1'b1;
                                r_col  <= '0;
                                r_row  <= ROW_BITS'(r_row_a) + ROW_BITS'(HALF_ROWS);
                                r_rgb  <= r_drain1[2:0];
                            end
                        end else begin
                            r_col <= w_col_inc;
                            r_rgb <= r_half ? r_drain1[w_base +: 3] : r_drain0[w_base +: 3];
                        end
                    end
                end
            endcase
        end
    end

    assign PIX_VALID = r_valid;
    assign PIX_ROW   = r_row;
    assign PIX_COL   = r_col;
    assign PIX_RGB   = r_rgb;
    assign LINE_DONE = r_line_done;

endmodule

// File: tb/tb_hub75_rx.sv
// tb_hub75_rx: randomized panel-bus stimulus against a row-pair reference model.
module tb_hub75_rx;

    localparam int unsigned COLS = 32;
    localparam int unsigned ROWS = 16;
`ifdef HUB75_RX_ERROR_CHECK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic       CLOCK      = 1'b0;
    logic       RESET_N    = 1'b0;
    logic       LP_CLOCK   = 1'b0;
    logic       LP_LATCH   = 1'b0;
    logic       LP_BLANK   = 1'b1;
    logic [2:0] LP_RGB_0   = 3'd0;
    logic [2:0] LP_RGB_1   = 3'd0;
    logic [4:0] LP_ADDRESS = 5'd0;
    logic       PIX_READY  = 1'b0;
    logic       PIX_VALID;
    logic [3:0] PIX_ROW;
    logic [4:0] PIX_COL;
    logic [2:0] PIX_RGB;
    logic       LINE_DONE, LENGTH_ERR, OVERRUN;

    hub75_rx #(.COLS(COLS), .ROWS(ROWS)) u_dut (
        .CLOCK(CLOCK), .RESET_N(RESET_N),
        .LP_CLOCK(LP_CLOCK), .LP_LATCH(LP_LATCH), .LP_BLANK(LP_BLANK),
        .LP_RGB_0(LP_RGB_0), .LP_RGB_1(LP_RGB_1), .LP_ADDRESS(LP_ADDRESS),
        .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY),
        .PIX_ROW(PIX_ROW), .PIX_COL(PIX_COL), .PIX_RGB(PIX_RGB),
        .LINE_DONE(LINE_DONE), .LENGTH_ERR(LENGTH_ERR), .OVERRUN(OVERRUN)
    );

    always #5 CLOCK = ~CLOCK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] beat(input int row, input int col, input logic [2:0] rgb);
        return {4'(row), 5'(col), rgb};
    endfunction

    // Sink readiness pattern: 0 always, 1 toggle, 2 random, 3 never.
    int ready_mode = 0;
    always @(posedge CLOCK) begin
        #1;
        case (ready_mode)
            0:       PIX_READY = 1'b1;
            1:       PIX_READY = ~PIX_READY;
            2:       PIX_READY = 1'($urandom_range(0, 1));
            default: PIX_READY = 1'b0;
        endcase
    end

    // Output monitor: collects transfers, counts LINE_DONE, checks hold-while-stalled.
    logic [11:0] cap[$];
    int          ld_count  = 0;
    bit          prev_hold = 1'b0;
    logic [11:0] prev_beat = '0;
    always @(negedge CLOCK) begin
        if (!RESET_N) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) check("hold", {PIX_VALID, PIX_ROW, PIX_COL, PIX_RGB}, {1'b1, prev_beat});
            if (LINE_DONE) begin
                ld_count++;
                check("ld_valid_low", PIX_VALID, 0);
            end
            if (PIX_VALID && PIX_READY) cap.push_back({PIX_ROW, PIX_COL, PIX_RGB});
            prev_hold = PIX_VALID && !PIX_READY;
            prev_beat = {PIX_ROW, PIX_COL, PIX_RGB};
        end
    end

    // Reference model: shift history, pending row, sticky flags, expected beats.
    logic [2:0]  h0[$], h1[$];
    int          m_cnt;
    bit          m_pend;
    logic [2:0]  m_p0[COLS], m_p1[COLS];
    int          m_ld_exp = 0;
    bit          m_len_err, m_overrun;
    logic [11:0] exp_q[$];

    task automatic model_reset();
        h0.delete(); h1.delete();
        for (int i = 0; i < COLS; i++) begin
            h0.push_back(3'd0); h1.push_back(3'd0);
        end
        m_cnt = 0; m_pend = 0; m_len_err = 0; m_overrun = 0;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic lp_shift(input logic [2:0] a, input logic [2:0] b);
        LP_RGB_0 = a; LP_RGB_1 = b;
        cyc(2); LP_CLOCK = 1'b1; cyc(3); LP_CLOCK = 1'b0; cyc(2);
        h0.push_back(a); h1.push_back(b);
        if (m_cnt < COLS + 1) m_cnt++;
    endtask

    task automatic shift_random(input int n);
        for (int i = 0; i < n; i++) lp_shift(3'($urandom), 3'($urandom));
    endtask

    // Column c of a latched row is the bit shifted c shifts before the latch.
    task automatic lp_latch();
        LP_LATCH = 1'b1; cyc(3); LP_LATCH = 1'b0; cyc(3);
        if (m_cnt == COLS || !ERRCHK) begin
            m_pend = 1;
            for (int c = 0; c < COLS; c++) begin
                m_p0[c] = h0[h0.size() - 1 - c];
                m_p1[c] = h1[h1.size() - 1 - c];
            end
        end else begin
            m_len_err = 1;
        end
        m_cnt = 0;
    endtask

    task automatic lp_unblank(input int addr, input bit busy);
        LP_ADDRESS = {2'($urandom), 3'(addr)};
        cyc(2); LP_BLANK = 1'b0; cyc(3); LP_BLANK = 1'b1; cyc(3);
        if (m_pend) begin
            if (busy) begin
                if (ERRCHK) m_overrun = 1;
            end else begin
                for (int c = 0; c < COLS; c++) exp_q.push_back(beat(addr, c, m_p0[c]));
                for (int c = 0; c < COLS; c++) exp_q.push_back(beat(addr + ROWS / 2, c, m_p1[c]));
                m_ld_exp++;
            end
            m_pend = 0;
        end
    endtask

    // Wait (bounded) for expected row completions, then compare everything seen.
    task automatic finish_row(input string tag);
        int t = 0;
        int n;
        while (ld_count < m_ld_exp && t < 3000) begin
            cyc(1); t++;
        end
        cyc(100);
        check({tag, "_line_done"}, ld_count, m_ld_exp);
        check({tag, "_nbeats"}, cap.size(), exp_q.size());
        n = (cap.size() < exp_q.size()) ? cap.size() : exp_q.size();
        for (int i = 0; i < n; i++) check({tag, "_beat"}, cap[i], exp_q[i]);
        check({tag, "_length_err"}, LENGTH_ERR, m_len_err);
        check({tag, "_overrun"}, OVERRUN, m_overrun);
        cap.delete(); exp_q.delete();
    endtask

    initial begin
        int t;
        model_reset();
        ready_mode = 0;
        cyc(3);
        check("rst_valid", PIX_VALID, 0);
        check("rst_row", PIX_ROW, 0);
        check("rst_col", PIX_COL, 0);
        check("rst_rgb", PIX_RGB, 0);
        check("rst_line_done", LINE_DONE, 0);
        check("rst_length_err", LENGTH_ERR, 0);
        check("rst_overrun", OVERRUN, 0);
        RESET_N = 1'b1;
        cyc(5);

        // Solid upper row, dark lower row.
        for (int i = 0; i < COLS; i++) lp_shift(3'b111, 3'b000);
        lp_latch(); lp_unblank(2, 0); finish_row("solid");

        // Single first bit lands in the last column.
        lp_shift(3'b001, 3'b000);
        for (int i = 1; i < COLS; i++) lp_shift(3'b000, 3'b000);
        lp_latch(); lp_unblank(5, 0); finish_row("first_bit");

        // Toggling ready.
        ready_mode = 1;
        shift_random(COLS); lp_latch(); lp_unblank(int'($urandom_range(0, 7)), 0);
        finish_row("toggle");

        // Random rows under random backpressure; one pending overwrite.
        ready_mode = 2;
        for (int k = 0; k < 4; k++) begin
            if (k == 1) begin
                shift_random(COLS); lp_latch();
            end
            shift_random(COLS); lp_latch(); lp_unblank(int'($urandom_range(0, 7)), 0);
            finish_row("random");
        end

        // Unblank with nothing pending is ignored.
        lp_unblank(3, 0); finish_row("idle_unblank");

        // Short row.
        ready_mode = 0;
        shift_random(COLS - 1); lp_latch(); lp_unblank(4, 0); finish_row("short_row");

        // Second row arrives while the first is stalled.
        ready_mode = 3;
        shift_random(COLS); lp_latch(); lp_unblank(1, 0);
        cyc(5);
        shift_random(COLS); lp_latch(); lp_unblank(6, 1);
        check("overrun_flag", OVERRUN, m_overrun);
        ready_mode = 0;
        finish_row("overrun");

        // Reset around beat 10 abandons the row.
        shift_random(COLS); lp_latch(); lp_unblank(3, 0);
        t = 0;
        while (cap.size() < 10 && t < 500) begin
            cyc(1); t++;
        end
        check("reached_beat10", cap.size() >= 10, 1);
        #1 RESET_N = 1'b0;
        #1;
        check("midrst_valid", PIX_VALID, 0);
        check("midrst_line_done", LINE_DONE, 0);
        cyc(3);
        RESET_N = 1'b1;
        model_reset();
        cap.delete(); exp_q.delete();
        m_ld_exp--;
        cyc(5);
        ready_mode = 2;
        shift_random(COLS); lp_latch(); lp_unblank(int'($urandom_range(0, 7)), 0);
        finish_row("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
